tbird_seq_lights: RTL and testbench
===================================

// Module: tbird_seq_lights
// PURPOSE
//  Parametrised tail-light sequencer: N lamps per side, animation paced by an
//  internal step prescaler rather than every clock. Adds a blinking hazard
//  mode and a brake overlay. Sits between the turn-signal and brake inputs and
//  the lamp drivers; one instance drives both sides.
// PARAMETERS
//  N_LAMPS   3  lamps per side (>=2); output width of l_lights/r_lights
//  TICK_DIV  4  clocks per animation step (>=1); 1 = step every clock
// PORTS
//  clk       in   1        rising-edge clock
//  rst       in   1        asynchronous, active-high reset
//  left      in   1        left turn request (level)
//  right     in   1        right turn request (level)
//  haz       in   1        hazard request (level)
//  brake     in   1        brake pedal (level), combinational overlay
//  l_lights  out  N_LAMPS  left lamps, bit0 = innermost
//  r_lights  out  N_LAMPS  right lamps, bit0 = innermost
//  busy      out  1        1 when state != IDLE
// BEHAVIOUR
//  Reset: state IDLE, pos 0, prescaler 0; while rst=1 l_lights=r_lights=0 and
//   busy=0 regardless of brake. Reset mid-sequence aborts immediately.
//  Prescaler: free-running 0..TICK_DIV-1 from reset release; step=1 when
//   count==TICK_DIV-1. First step is the TICK_DIV-th clock after reset release.
//  left/right/haz are sampled only on step cycles; pulses between steps are ignored.
//  State and pos change only on step cycles; otherwise hold.
//  Let hz = haz | (left & right).
//  States / transitions (on step):
//   IDLE    : hz -> HAZ_ON; else left -> LEFT pos=1; else right -> RIGHT pos=1;
//             else IDLE.
//   LEFT    : haz -> HAZ_ON; pos<N_LAMPS -> pos+1; pos==N_LAMPS -> IDLE.
//   RIGHT   : same as LEFT, mirrored.
//   HAZ_ON  : -> HAZ_OFF.
//   HAZ_OFF : hz -> HAZ_ON; else IDLE.
//  Sweep runs to completion once started: releasing left/right or raising the
//   opposite side mid-sweep has no effect; only haz preempts a sweep.
//  pos width $clog2(N_LAMPS+1); pos=0 outside LEFT/RIGHT.
//  Lamp pattern (combinational from state, pos):
//   IDLE: 0/0. LEFT: l = thermometer of pos ones from bit0 ((1<<pos)-1), r=0.
//   RIGHT: mirrored. HAZ_ON: all ones both sides. HAZ_OFF: 0/0.
//  Brake overlay (combinational, zero latency): in IDLE, LEFT and RIGHT, a side
//   not being swept shows all ones while brake=1. The swept side keeps its
//   pattern. In HAZ_ON/HAZ_OFF, brake is ignored.
//  busy = (state != IDLE); no registered output latency beyond state.
// TESTING (N_LAMPS=3, TICK_DIV=4 unless stated; cycle 0 = first clk after rst)
//  1 left held -> l_lights 001,011,111,000 at steps on cycles 3,7,11,15; repeats; r=000.
//  2 left, then haz=1 while l=011 -> next step both 111, then 000, alternating
//    each step while haz=1; drop haz in HAZ_OFF -> IDLE, 000/000.
//  3 left=right=1 from IDLE -> HAZ_ON at first step; 1-cycle left pulse off-step -> no change.
//  4 right held + brake=1 -> l_lights=111 constantly, r sweeps 001,011,111; brake in
//    HAZ_OFF -> 000/000.
//  5 rst asserted asynchronously mid-HAZ_ON with brake=1 -> outputs 000/000, busy=0
//    before next edge; first step after release on the 4th clock.
//  6 N_LAMPS=5, TICK_DIV=1, left held -> 00001..11111 on consecutive clocks, then 00000.

Source files
------------

// File: rtl/tbird_seq_lights.sv
// rtl/tbird_seq_lights.sv - parametrised tail-light sequencer with hazard mode and brake overlay
module tbird_seq_lights #(
    parameter int N_LAMPS  = 3,
    parameter int TICK_DIV = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               left,
    input  logic               right,
    input  logic               haz,
    input  logic               brake,
    output logic [N_LAMPS-1:0] l_lights,
    output logic [N_LAMPS-1:0] r_lights,
    output logic               busy
);
    localparam int PW = $clog2(N_LAMPS + 1);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LEFT    = 3'd1,
        RIGHT   = 3'd2,
        HAZ_ON  = 3'd3,
        HAZ_OFF = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   pos_q, pos_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            step;
    logic            hz;
    logic [N_LAMPS-1:0] therm;
    logic [N_LAMPS-1:0] ones;

    assign step  = (cnt_q == CW'(TICK_DIV - 1));
    assign cnt_d = step ? '0 : cnt_q + 1'b1;
    assign hz    = haz | (left & right);
    assign ones  = '1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pos_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            cnt_q   <= cnt_d;
        end
    end

    // Requests are only looked at on step cycles; a started sweep yields only to haz.
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        if (step) begin
            case (state_q)
                IDLE: begin
                    if (hz) begin
                        state_d = HAZ_ON;
                    end else if (left) begin
                        state_d = LEFT;
                        pos_d   = PW'(1);
                    end else if (right) begin
                        state_d = RIGHT;
                        pos_d   = PW'(1);
                    end
                end
                LEFT, RIGHT: begin
                    if (haz) begin
                        state_d = HAZ_ON;
                        pos_d   = '0;
                    end else if (pos_q < PW'(N_LAMPS)) begin
                        pos_d = pos_q + 1'b1;
                    end else begin
                        state_d = IDLE;
                        pos_d   = '0;
                    end
                end
                HAZ_ON:  state_d = HAZ_OFF;
                HAZ_OFF: state_d = hz ? HAZ_ON : IDLE;
                default: begin
                    state_d = IDLE;
                    pos_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        therm = '0;
        for (int i = 0; i < N_LAMPS; i++) begin
            therm[i] = (i < int'(pos_q));
        end
    end

    // Brake lights the non-swept side(s); the hazard states ignore it. Reset blanks everything.
    always_comb begin
        l_lights = '0;
        r_lights = '0;
        case (state_q)
            IDLE: begin
                if (brake) begin
                    l_lights = ones;
                    r_lights = ones;
                end
            end
            LEFT: begin
                l_lights = therm;
                if (brake) r_lights = ones;
            end
            RIGHT: begin
                r_lights = therm;
                if (brake) l_lights = ones;
            end
            HAZ_ON: begin
                l_lights = ones;
                r_lights = ones;
            end
            default: begin
                l_lights = '0;
                r_lights = '0;
            end
        endcase
        if (rst) begin
            l_lights = '0;
            r_lights = '0;
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_tbird_seq_lights.sv
// tb/tb_tbird_seq_lights.sv - directed and random checks of two sequencer configurations against a behavioural model
module tb_tbird_seq_lights;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic left = 1'b0, right = 1'b0, haz = 1'b0, brake = 1'b0;
    logic [2:0] l0, r0;
    logic [4:0] l1, r1;
    logic       b0, b1;

    int checks = 0;
    int failures = 0;

    localparam int M_IDLE = 0, M_LEFT = 1, M_RIGHT = 2, M_HON = 3, M_HOFF = 4;

    int nl[2] = '{3, 5};
    int dv[2] = '{4, 1};
    int md[2];
    int ps[2];
    int cn[2];

    always #5 clk = ~clk;

    tbird_seq_lights #(.N_LAMPS(3), .TICK_DIV(4)) dut0 (
        .clk(clk), .rst(rst), .left(left), .right(right), .haz(haz), .brake(brake),
        .l_lights(l0), .r_lights(r0), .busy(b0)
    );

    tbird_seq_lights #(.N_LAMPS(5), .TICK_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .left(left), .right(right), .haz(haz), .brake(brake),
        .l_lights(l1), .r_lights(r1), .busy(b1)
    );

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            md[k] = M_IDLE;
            ps[k] = 0;
            cn[k] = 0;
        end
    endfunction

    function automatic int pat(int k, int side);
        int all;
        all = (1 << nl[k]) - 1;
        if (rst) return 0;
        case (md[k])
            M_IDLE:  return brake ? all : 0;
            M_LEFT:  return (side == 0) ? (1 << ps[k]) - 1 : (brake ? all : 0);
            M_RIGHT: return (side == 1) ? (1 << ps[k]) - 1 : (brake ? all : 0);
            M_HON:   return all;
            default: return 0;
        endcase
    endfunction

    function automatic void model_step();
        bit hzr;
        hzr = haz | (left & right);
        for (int k = 0; k < 2; k++) begin
            if (cn[k] == dv[k] - 1) begin
                cn[k] = 0;
                case (md[k])
                    M_IDLE: begin
                        if (hzr) md[k] = M_HON;
                        else if (left) begin md[k] = M_LEFT; ps[k] = 1; end
                        else if (right) begin md[k] = M_RIGHT; ps[k] = 1; end
                    end
                    M_LEFT, M_RIGHT: begin
                        if (haz) begin md[k] = M_HON; ps[k] = 0; end
                        else if (ps[k] < nl[k]) ps[k] = ps[k] + 1;
                        else begin md[k] = M_IDLE; ps[k] = 0; end
                    end
                    M_HON:   md[k] = M_HOFF;
                    default: md[k] = hzr ? M_HON : M_IDLE;
                endcase
            end else begin
                cn[k] = cn[k] + 1;
            end
        end
    endfunction

    task automatic check_outputs(input string tag);
        logic [2:0] el0, er0;
        logic [4:0] el1, er1;
        logic       eb0, eb1;
        el0 = 3'(pat(0, 0)); er0 = 3'(pat(0, 1));
        el1 = 5'(pat(1, 0)); er1 = 5'(pat(1, 1));
        eb0 = (md[0] != M_IDLE); eb1 = (md[1] != M_IDLE);
        checks++; assert (l0 === el0) else begin failures++; $error("FAIL %s l0 got=%b exp=%b", tag, l0, el0); end
        checks++; assert (r0 === er0) else begin failures++; $error("FAIL %s r0 got=%b exp=%b", tag, r0, er0); end
        checks++; assert (b0 === eb0) else begin failures++; $error("FAIL %s busy0 got=%b exp=%b", tag, b0, eb0); end
        checks++; assert (l1 === el1) else begin failures++; $error("FAIL %s l1 got=%b exp=%b", tag, l1, el1); end
        checks++; assert (r1 === er1) else begin failures++; $error("FAIL %s r1 got=%b exp=%b", tag, r1, er1); end
        checks++; assert (b1 === eb1) else begin failures++; $error("FAIL %s busy1 got=%b exp=%b", tag, b1, eb1); end
    endtask

    // Entered and left at a falling edge: drive, check, clock, advance model.
    task automatic cycle(input bit l, input bit r, input bit h, input bit b, input string tag);
        left = l; right = r; haz = h; brake = b;
        #1 check_outputs(tag);
        @(posedge clk);
        if (!rst) model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        cycle(0, 0, 0, 1, "reset");
        cycle(0, 0, 0, 1, "reset");
        rst = 1'b0;
    endtask

    task automatic expect_true(input bit cond, input string tag);
        checks++;
        assert (cond) else begin failures++; $error("FAIL %s bound expired got=0 exp=1", tag); end
    endtask

    initial begin
        int n;
        logic [2:0] exp_l;
        @(negedge clk);
        do_reset();

        // left held: exact 3-lamp sweep on steps at cycles 3,7,11,15
        for (int c = 0; c < 16; c++) begin
            cycle(1, 0, 0, 0, "left_sweep");
            if (c < 3) exp_l = 3'b000;
            else if (c < 7) exp_l = 3'b001;
            else if (c < 11) exp_l = 3'b011;
            else if (c < 15) exp_l = 3'b111;
            else exp_l = 3'b000;
            checks++;
            assert (l0 === exp_l && r0 === 3'b000)
                else begin failures++; $error("FAIL left_const c=%0d got=%b/%b exp=%b/000", c, l0, r0, exp_l); end
        end

        // left then haz while l=011; drop haz in HAZ_OFF
        do_reset();
        n = 0;
        while (!(md[0] == M_LEFT && ps[0] == 2) && n < 40) begin cycle(1, 0, 0, 0, "pre_haz"); n++; end
        expect_true(md[0] == M_LEFT && ps[0] == 2, "reach_l011");
        for (int c = 0; c < 12; c++) cycle(1, 0, 1, 0, "haz_blink");
        n = 0;
        while (md[0] != M_HOFF && n < 40) begin cycle(0, 0, 1, 0, "haz_to_off"); n++; end
        expect_true(md[0] == M_HOFF, "reach_hoff");
        for (int c = 0; c < 8; c++) cycle(0, 0, 0, 0, "haz_drop");

        // left&right from IDLE -> hazard; off-step left pulse ignored by the divided instance
        do_reset();
        for (int c = 0; c < 4; c++) cycle(1, 1, 0, 0, "lr_haz");
        for (int c = 0; c < 8; c++) cycle(0, 0, 0, 0, "lr_settle");
        n = 0;
        while (cn[0] != 1 && n < 8) begin cycle(0, 0, 0, 0, "align"); n++; end
        cycle(1, 0, 0, 0, "pulse");
        for (int c = 0; c < 6; c++) cycle(0, 0, 0, 0, "post_pulse");
        expect_true(md[0] == M_IDLE, "pulse_ignored");

        // right sweep under brake, then brake during hazard-off
        do_reset();
        for (int c = 0; c < 16; c++) cycle(0, 1, 0, 1, "right_brake");
        n = 0;
        while (md[0] != M_HOFF && n < 40) begin cycle(0, 0, 1, 1, "haz_brake"); n++; end
        expect_true(md[0] == M_HOFF, "reach_hoff_brake");
        cycle(0, 0, 0, 1, "hoff_brake");

        // asynchronous reset mid-HAZ_ON with brake held
        do_reset();
        n = 0;
        while (md[0] != M_HON && n < 40) begin cycle(0, 0, 1, 1, "to_hon"); n++; end
        expect_true(md[0] == M_HON, "reach_hon");
        left = 0; right = 0; haz = 1; brake = 1;
        #2 rst = 1'b1;
        model_reset();
        #1 check_outputs("async_rst");
        @(negedge clk);
        cycle(0, 0, 0, 1, "in_rst");
        rst = 1'b0;
        for (int c = 0; c < 4; c++) cycle(1, 0, 0, 0, "post_rst");
        expect_true(md[0] == M_LEFT && ps[0] == 1, "first_step_4th");

        // randomized
        do_reset();
        for (int c = 0; c < 600; c++) begin
            cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 9) == 0), $urandom_range(0, 1), "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
